fifo_wr_seq: RTL and testbench

FIFO_WR_SEQ -- requirements
Module: fifo_wr_seq

---
 rtl/fifo_wr_seq.sv | 107 ++++++++++
 tb/tb_fifo_wr_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_seq.sv
// fifo_wr_seq: accepts a packed multi-word request and pushes its words into
// an async FIFO write port one per cycle, word 0 first, stalling while full.
// Also keeps a sticky illegal-length flag and a saturating stall counter.
module fifo_wr_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 2,
    localparam int LEN_W     = $clog2(NUM_BYTES) + 1
) (
    input  logic                            W_CLK,
    input  logic                            W_RST,
    input  logic                            req_valid,
    input  logic [DATA_WIDTH*NUM_BYTES-1:0] req_data,
    input  logic [LEN_W-1:0]                req_len,
    output logic                            req_ready,
    input  logic                            full,
    output logic                            W_inc,
    output logic [DATA_WIDTH-1:0]           W_data,
    output logic                            busy,
    output logic                            done,
    input  logic                            clr_err,
    output logic                            len_err,
    output logic [7:0]                      stall_cnt
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_BYTES);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_t                          state_q;
    state_t                          state_d;
    logic [DATA_WIDTH*NUM_BYTES-1:0] shreg;
    logic [LEN_W-1:0]                cnt;
    logic                            len_ok;
    logic                            accept;
    logic                            write;
    logic                            last;

    // Saturating increment so the stall counter parks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign len_ok = (req_len != '0) && (req_len <= MAX_LEN);
    assign accept = (state_q == IDLE) && req_valid && len_ok;
    assign write  = (state_q == SEND) && !full;
    assign last   = write && (cnt == ONE);

    // State register.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: leave IDLE on a legal request, return once the last word is written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SEND;
            SEND:    if (last)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; the write enable follows full combinationally.
    always_comb begin
        req_ready = (state_q == IDLE);
        busy      = (state_q == SEND);
        W_inc     = (state_q == SEND) && !full;
        W_data    = shreg[DATA_WIDTH-1:0];
    end

    // Payload shift register and remaining-word count; held while full.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shreg <= req_data;
            cnt   <= req_len;
        end else if (write) begin
            shreg <= shreg >> DATA_WIDTH;
            cnt   <= cnt - ONE;
        end
    end

    // One-cycle done pulse following the final write of a request.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) done <= 1'b0;
        else        done <= last;
    end

    // Sticky length error and stall counter; a clear beats a same-cycle set.
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            len_err   <= 1'b0;
            stall_cnt <= 8'd0;
        end else if (clr_err) begin
            len_err   <= 1'b0;
            stall_cnt <= 8'd0;
        end else begin
            if ((state_q == IDLE) && req_valid && !len_ok) len_err <= 1'b1;
            if ((state_q == SEND) && full) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_fifo_wr_seq.sv
// Self-checking bench for fifo_wr_seq: directed scenarios plus a randomized
// run against a queue-based reference model of the word stream.
module tb_fifo_wr_seq;

    localparam int DW    = 8;
    localparam int NB    = 2;
    localparam int LEN_W = $clog2(NB) + 1;

    logic             W_CLK = 1'b0;
    logic             W_RST = 1'b0;
    logic             req_valid = 1'b0;
    logic [DW*NB-1:0] req_data = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic             req_ready;
    logic             full = 1'b0;
    logic             W_inc;
    logic [DW-1:0]    W_data;
    logic             busy;
    logic             done;
    logic             clr_err = 1'b0;
    logic             len_err;
    logic [7:0]       stall_cnt;

    logic [3:0] flags;
    assign flags = {req_ready, busy, W_inc, done};

    int passed = 0;
    int total  = 0;

    fifo_wr_seq #(.DATA_WIDTH(DW), .NUM_BYTES(NB)) dut (
        .W_CLK(W_CLK), .W_RST(W_RST), .req_valid(req_valid), .req_data(req_data),
        .req_len(req_len), .req_ready(req_ready), .full(full), .W_inc(W_inc),
        .W_data(W_data), .busy(busy), .done(done), .clr_err(clr_err),
        .len_err(len_err), .stall_cnt(stall_cnt)
    );

    always #5 W_CLK = ~W_CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

    task automatic nxt();
        @(posedge W_CLK); #1;
    endtask

    task automatic smp();
        @(negedge W_CLK);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_data = '0; req_len = '0; full = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        W_RST = 1'b0;
        idle_inputs();
        smp(); smp();
        W_RST = 1'b1;
        nxt();
    endtask

    task automatic test_reset();
        W_RST = 1'b0;
        idle_inputs();
        smp(); smp();
        total++; if (flags !== 4'b1000) $display("FAIL rst_flags got=%b exp=%b", flags, 4'b1000); else passed++;
        total++; if (W_data !== 8'h00) $display("FAIL rst_wdata got=%h exp=%h", W_data, 8'h00); else passed++;
        total++; if ({len_err, stall_cnt} !== 9'd0) $display("FAIL rst_err got=%b/%0d exp=0/0", len_err, stall_cnt); else passed++;
        // release at a falling edge with a request waiting: taken on the first rising edge
        W_RST = 1'b1; req_valid = 1'b1; req_data = 16'hC3A5; req_len = 2'd2;
        nxt(); req_valid = 1'b0;
        smp();
        total++; if (flags !== 4'b0110) $display("FAIL rst_first_accept got=%b exp=%b", flags, 4'b0110); else passed++;
        total++; if (W_data !== 8'hA5) $display("FAIL rst_first_word got=%h exp=%h", W_data, 8'hA5); else passed++;
        repeat (3) nxt();
    endtask

    task automatic test_basic();
        do_reset();
        req_valid = 1'b1; req_data = 16'hBEEF; req_len = 2'd2;
        smp();
        total++; if (flags !== 4'b1000) $display("FAIL basic_idle got=%b exp=%b", flags, 4'b1000); else passed++;
        nxt(); req_valid = 1'b0; smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'hEF) $display("FAIL basic_w0 got=%b/%h exp=0110/ef", flags, W_data); else passed++;
        nxt(); smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'hBE) $display("FAIL basic_w1 got=%b/%h exp=0110/be", flags, W_data); else passed++;
        nxt(); smp();
        total++; if (flags !== 4'b1001) $display("FAIL basic_done got=%b exp=%b", flags, 4'b1001); else passed++;
        nxt(); smp();
        total++; if (flags !== 4'b1000) $display("FAIL basic_after got=%b exp=%b", flags, 4'b1000); else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 1'b1; req_data = 16'hBEEF; req_len = 2'd2;
        nxt(); req_valid = 1'b0; smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'hEF) $display("FAIL bp_w0 got=%b/%h exp=0110/ef", flags, W_data); else passed++;
        nxt(); full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            total++; if (flags !== 4'b0100 || W_data !== 8'hBE) $display("FAIL bp_stall%0d got=%b/%h exp=0100/be", k, flags, W_data); else passed++;
            nxt();
        end
        full = 1'b0; smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'hBE) $display("FAIL bp_w1 got=%b/%h exp=0110/be", flags, W_data); else passed++;
        total++; if (stall_cnt !== 8'd3) $display("FAIL bp_stall_cnt got=%0d exp=3", stall_cnt); else passed++;
        nxt(); smp();
        total++; if (flags !== 4'b1001) $display("FAIL bp_done got=%b exp=%b", flags, 4'b1001); else passed++;
        // a new request does not clear the stall count
        req_valid = 1'b1; req_data = 16'h0077; req_len = 2'd1;
        nxt(); req_valid = 1'b0; nxt(); smp();
        total++; if (stall_cnt !== 8'd3) $display("FAIL bp_stall_keep got=%0d exp=3", stall_cnt); else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        req_valid = 1'b1; req_data = 16'h1111; req_len = 2'd0;
        nxt(); req_valid = 1'b0; smp();
        total++; if (len_err !== 1'b1 || flags !== 4'b1000) $display("FAIL ill_len0 got=%b/%b exp=1/1000", len_err, flags); else passed++;
        clr_err = 1'b1; nxt(); clr_err = 1'b0; smp();
        total++; if (len_err !== 1'b0) $display("FAIL ill_clear got=%b exp=0", len_err); else passed++;
        req_valid = 1'b1; req_len = 2'd3;
        smp();
        total++; if (W_inc !== 1'b0) $display("FAIL ill_no_inc got=%b exp=0", W_inc); else passed++;
        nxt(); req_valid = 1'b0; smp();
        total++; if (len_err !== 1'b1 || flags !== 4'b1000) $display("FAIL ill_len3 got=%b/%b exp=1/1000", len_err, flags); else passed++;
        req_valid = 1'b1; req_len = 2'd0; clr_err = 1'b1;
        nxt(); req_valid = 1'b0; clr_err = 1'b0; smp();
        total++; if (len_err !== 1'b0) $display("FAIL ill_clear_wins got=%b exp=0", len_err); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 1'b1; req_data = 16'h005A; req_len = 2'd1;
        nxt(); req_data = 16'h1234; req_len = 2'd2; smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'h5A) $display("FAIL b2b_single got=%b/%h exp=0110/5a", flags, W_data); else passed++;
        nxt(); smp();
        total++; if (flags !== 4'b1001) $display("FAIL b2b_done_ready got=%b exp=%b", flags, 4'b1001); else passed++;
        nxt(); req_valid = 1'b0; smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'h34) $display("FAIL b2b_w0 got=%b/%h exp=0110/34", flags, W_data); else passed++;
        nxt(); smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'h12) $display("FAIL b2b_w1 got=%b/%h exp=0110/12", flags, W_data); else passed++;
        nxt(); smp();
        total++; if (flags !== 4'b1001) $display("FAIL b2b_done2 got=%b exp=%b", flags, 4'b1001); else passed++;
    endtask

    task automatic test_reset_mid();
        int writes;
        writes = 0;
        do_reset();
        req_valid = 1'b1; req_data = 16'hBEEF; req_len = 2'd2;
        nxt(); req_valid = 1'b0; smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'hEF) $display("FAIL rmid_w0 got=%b/%h exp=0110/ef", flags, W_data); else passed++;
        nxt();
        W_RST = 1'b0; #1;
        total++; if (flags !== 4'b1000 || W_data !== 8'h00) $display("FAIL rmid_abort got=%b/%h exp=1000/00", flags, W_data); else passed++;
        smp(); W_RST = 1'b1;
        repeat (6) begin
            smp();
            if (W_inc === 1'b1) writes++;
        end
        total++; if (writes != 0) $display("FAIL rmid_no_writes got=%0d exp=0", writes); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 1'b1; req_data = 16'hBEEF; req_len = 2'd2;
        nxt(); req_valid = 1'b0; full = 1'b1;
        repeat (300) nxt();
        smp();
        total++; if (stall_cnt !== 8'd255) $display("FAIL sat_cnt got=%0d exp=255", stall_cnt); else passed++;
        total++; if (flags !== 4'b0100 || W_data !== 8'hEF) $display("FAIL sat_hold got=%b/%h exp=0100/ef", flags, W_data); else passed++;
        nxt(); full = 1'b0; clr_err = 1'b1; smp();
        total++; if (flags !== 4'b0110 || W_data !== 8'hEF) $display("FAIL sat_resume got=%b/%h exp=0110/ef", flags, W_data); else passed++;
        total++; if (stall_cnt !== 8'd255) $display("FAIL sat_cnt_held got=%0d exp=255", stall_cnt); else passed++;
        nxt(); clr_err = 1'b0; smp();
        total++; if (stall_cnt !== 8'd0 || W_data !== 8'hBE) $display("FAIL sat_clear got=%0d/%h exp=0/be", stall_cnt, W_data); else passed++;
        nxt(); nxt();
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int         m_stall;
        bit         m_done;
        bit         m_lerr;
        bit         exp_busy;
        bit         exp_inc;
        logic [3:0] exp_flags;
        do_reset();
        m_stall = 0; m_done = 0; m_lerr = 0;
        for (int c = 0; c < 600; c++) begin
            bit nd;
            req_valid = ($urandom % 3) == 0;
            req_len   = LEN_W'($urandom_range(0, 3));
            req_data  = DW*NB'($urandom);
            full      = ($urandom % 4) == 0;
            clr_err   = ($urandom % 40) == 0;
            smp();
            exp_busy  = q.size() != 0;
            exp_inc   = exp_busy && !full;
            exp_flags = {!exp_busy, exp_busy, exp_inc, m_done};
            total++; if (flags !== exp_flags) $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, flags, exp_flags); else passed++;
            if (exp_inc) begin
                total++; if (W_data !== q[0]) $display("FAIL rnd_data c=%0d got=%h exp=%h", c, W_data, q[0]); else passed++;
            end
            total++; if (len_err !== m_lerr) $display("FAIL rnd_len_err c=%0d got=%b exp=%b", c, len_err, m_lerr); else passed++;
            total++; if (int'(stall_cnt) != m_stall) $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, stall_cnt, m_stall); else passed++;
            // reference model: the outstanding words of the accepted request
            nd = 1'b0;
            if (q.size() != 0) begin
                if (full) begin
                    m_stall = (m_stall >= 255) ? 255 : m_stall + 1;
                end else begin
                    void'(q.pop_front());
                    if (q.size() == 0) nd = 1'b1;
                end
            end else if (req_valid) begin
                if (req_len >= 1 && req_len <= NB) begin
                    for (int i = 0; i < int'(req_len); i++) q.push_back(req_data[DW*i +: DW]);
                end else begin
                    m_lerr = 1'b1;
                end
            end
            if (clr_err) begin
                m_lerr  = 1'b0;
                m_stall = 0;
            end
            m_done = nd;
            nxt();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
